// File: rtl/bcd_updown_counter.sv
// ============================================================================
// Module   : bcd_updown_counter
// Function : DIGITS-decade synchronous BCD up/down counter with parallel load,
//            invalid-digit load flag and cascade terminal count.
//            Define BCD_SATURATE_EN to hold at the terminal values instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_updown_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  load_err
);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                load_err_q, load_err_d;

    logic [4*DIGITS-1:0] w_load_clean;
    logic [4*DIGITS-1:0] w_step_val;
    logic [DIGITS-1:0]   w_digit_bad;
    logic [DIGITS-1:0]   w_digit_9;
    logic [DIGITS-1:0]   w_digit_0;
    logic                w_all9;
    logic                w_all0;
    logic                w_sat_hold;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] w_ld;
            assign w_ld                   = load_val[gi*4 +: 4];
            assign w_digit_bad[gi]        = (w_ld > 4'd9);
            assign w_load_clean[gi*4 +: 4] = (w_ld > 4'd9) ? 4'd0 : w_ld;
            assign w_digit_9[gi]          = (count_q[gi*4 +: 4] == 4'd9);
            assign w_digit_0[gi]          = (count_q[gi*4 +: 4] == 4'd0);
        end
    endgenerate

    assign w_all9 = &w_digit_9;
    assign w_all0 = &w_digit_0;

`ifdef BCD_SATURATE_EN
    assign w_sat_hold = up ? w_all9 : w_all0;
`else
    assign w_sat_hold = 1'b0;
`endif

    // A digit steps only when every lower digit is rolling over in the same direction.
    always_comb begin
        logic w_ripple;
        w_step_val = count_q;
        w_ripple   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_ripple) begin
                if (up) begin
                    w_step_val[i*4 +: 4] = w_digit_9[i] ? 4'd0 : count_q[i*4 +: 4] + 4'd1;
                end else begin
                    w_step_val[i*4 +: 4] = w_digit_0[i] ? 4'd9 : count_q[i*4 +: 4] - 4'd1;
                end
            end
            w_ripple = w_ripple & (up ? w_digit_9[i] : w_digit_0[i]);
        end
    end

    always_comb begin
        count_d    = count_q;
        load_err_d = 1'b0;
        if (load) begin
            count_d    = w_load_clean;
            load_err_d = |w_digit_bad;
        end else if (en && !w_sat_hold) begin
            count_d    = w_step_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign load_err = load_err_q;
    assign tc       = en & ~load & (up ? w_all9 : w_all0);

endmodule

`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
// ============================================================================
// Module   : tb_bcd_updown_counter
// Function : Self-checking bench for bcd_updown_counter (DIGITS=2) against an
//            integer reference model, plus a two-instance cascade.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_updown_counter;

`ifdef BCD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int MAXV = 99;

    logic       clk;
    logic       reset, en, up, load;
    logic [7:0] load_val, count;
    logic       tc, load_err;

    logic       c_reset, c_load, c_en, c_up;
    logic [7:0] c_lv_lo, c_lv_hi, c_cnt_lo, c_cnt_hi;
    logic       c_tc_lo, c_tc_hi, c_err_lo, c_err_hi;

    int errors = 0;
    int checks = 0;
    int m_val  = 0;
    bit m_err  = 1'b0;

    bcd_updown_counter #(.DIGITS(2)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .tc(tc), .load_err(load_err)
    );

    bcd_updown_counter #(.DIGITS(2)) u_lo (
        .clk(clk), .reset(c_reset), .en(c_en), .up(c_up), .load(c_load),
        .load_val(c_lv_lo), .count(c_cnt_lo), .tc(c_tc_lo), .load_err(c_err_lo)
    );

    bcd_updown_counter #(.DIGITS(2)) u_hi (
        .clk(clk), .reset(c_reset), .en(c_tc_lo), .up(c_up), .load(c_load),
        .load_val(c_lv_hi), .count(c_cnt_hi), .tc(c_tc_hi), .load_err(c_err_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    // Decimal value of a load word with invalid digits replaced by zero.
    function automatic int load_value(input logic [7:0] lv);
        int lo = int'(lv[3:0]);
        int hi = int'(lv[7:4]);
        if (lo > 9) lo = 0;
        if (hi > 9) hi = 0;
        return hi * 10 + lo;
    endfunction

    task automatic cycle(input logic r, input logic l, input logic e,
                         input logic u, input logic [7:0] lv);
        bit exp_tc;
        @(negedge clk);
        reset = r; load = l; en = e; up = u; load_val = lv;
        exp_tc = e && !l && (u ? (m_val == MAXV) : (m_val == 0));
        #1 check("tc", 32'(tc), 32'(exp_tc));
        @(posedge clk);
        if (!r) begin
            m_val = 0;
            m_err = 1'b0;
        end else if (l) begin
            m_val = load_value(lv);
            m_err = (lv[3:0] > 4'd9) || (lv[7:4] > 4'd9);
        end else begin
            m_err = 1'b0;
            if (e) begin
                if (u) m_val = (m_val == MAXV) ? (SAT ? MAXV : 0) : m_val + 1;
                else   m_val = (m_val == 0) ? (SAT ? 0 : MAXV) : m_val - 1;
            end
        end
        #1;
        check("count", 32'(count), 32'(to_bcd(m_val)));
        check("load_err", 32'(load_err), 32'(m_err));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
        c_reset = 1'b1; c_load = 1'b0; c_en = 1'b0; c_up = 1'b1;
        c_lv_lo = 8'h00; c_lv_hi = 8'h00;

        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);

        // Full up sweep plus one extra edge to observe wrap or saturation.
        for (int i = 0; i < 101; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);

        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h10);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

        cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h47);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'hA5);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h9F);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'hCB);

        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h42);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h33);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h58);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Direction flips while enabled.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b1, 1'(i % 2), 8'h00);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 32) != 0, ($urandom % 8) == 0, 1'($urandom),
                  1'($urandom), 8'($urandom));
        end

        // Cascade: low instance tc enables the high instance.
        @(negedge clk); c_reset = 1'b0;
        @(negedge clk); c_reset = 1'b1; c_load = 1'b1; c_lv_lo = 8'h99; c_lv_hi = 8'h00;
        @(negedge clk); c_load = 1'b0; c_en = 1'b1; c_up = 1'b1;
        #1 check("cascade_tc_lo", 32'(c_tc_lo), 32'h1);
        @(posedge clk); #1;
        check("cascade_count", 32'({c_cnt_hi, c_cnt_lo}), 32'h0100);
        @(negedge clk); c_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
